// File: rtl/rpn_sequencer.sv
// rpn_sequencer
//   Sequences an RPN stack calculator from a stream of tokens. Each accepted
//   token is checked against a tracked stack depth; legal tokens produce one
//   calculator step, an end token at depth 1 returns the calculator's top of
//   stack over a result handshake. An illegal token latches a sticky error and
//   discards tokens up to the next end token, after which the calculator is
//   cleared.
//
// Ports
//   clk, nrst               clock (rising edge), asynchronous active-low reset
//   tok_valid/tok_ready     token handshake
//   tok_kind                00 push, 01 op, 10 end, 11 reserved
//   tok_op                  00 pass, 01 negate, 10 add, 11 multiply
//   tok_data                push value
//   calc_step               one-cycle step strobe to the calculator
//   calc_push/op/d          step fields, zero outside the step cycle
//   calc_clr                one-cycle calculator clear
//   calc_out                calculator top of stack
//   res_valid/res_ready     result handshake, res_data holds the result
//   depth                   tracked stack depth
//   err, err_code           sticky error: 01 underflow, 10 overflow, 11 bad end/kind
module rpn_sequencer #(
    parameter int DW        = 16,
    parameter int AW        = 10,
    parameter int DEPTH_MAX = 1023,
    parameter int STEP_GAP  = 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          tok_valid,
    output logic          tok_ready,
    input  logic [1:0]    tok_kind,
    input  logic [1:0]    tok_op,
    input  logic [DW-1:0] tok_data,
    output logic          calc_step,
    output logic          calc_push,
    output logic [1:0]    calc_op,
    output logic [DW-1:0] calc_d,
    output logic          calc_clr,
    input  logic [DW-1:0] calc_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic [AW:0]   depth,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] RESULT = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;
    localparam logic [2:0] CLEAR  = 3'd5;

    localparam logic [1:0] K_PUSH = 2'b00;
    localparam logic [1:0] K_OP   = 2'b01;
    localparam logic [1:0] K_END  = 2'b10;

    localparam logic [1:0] E_UNDER = 2'b01;
    localparam logic [1:0] E_OVER  = 2'b10;
    localparam logic [1:0] E_BAD   = 2'b11;

    localparam int            CW       = (STEP_GAP > 1) ? $clog2(STEP_GAP + 1) : 1;
    localparam logic [AW:0]   DMAX     = (AW+1)'(DEPTH_MAX);
    localparam logic [AW:0]   D_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   D_TWO    = (AW+1)'(2);
    // GAP_LAST is only used when STEP_GAP > 0.
    localparam logic [CW-1:0] GAP_LAST = CW'(STEP_GAP - 1);
    localparam logic [CW-1:0] GAP_FULL = CW'(STEP_GAP);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          push_r;
    logic [1:0]    op_r;
    logic [DW-1:0] data_r;
    logic [AW:0]   depth_r;
    logic          err_r;
    logic [1:0]    err_code_r;
    logic          res_valid_r;
    logic [DW-1:0] res_data_r;
    logic          tok_xfer;
    logic          issue;

    // Gated by nrst so tok_ready is also 0 while reset is held.
    assign tok_ready = nrst && ((state == IDLE) || (state == DRAIN));
    assign tok_xfer  = tok_valid && tok_ready;
    assign issue     = (state == ISSUE);

    assign calc_step = issue;
    assign calc_push = issue && push_r;
    assign calc_op   = issue ? op_r : '0;
    assign calc_d    = issue ? data_r : '0;
    assign calc_clr  = (state == CLEAR);
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign depth     = depth_r;
    assign err       = err_r;
    assign err_code  = err_code_r;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            cnt         <= '0;
            push_r      <= 1'b0;
            op_r        <= '0;
            data_r      <= '0;
            depth_r     <= '0;
            err_r       <= 1'b0;
            err_code_r  <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tok_xfer) begin
                        push_r     <= (tok_kind == K_PUSH);
                        op_r       <= tok_op;
                        data_r     <= tok_data;
                        cnt        <= '0;
                        // Cleared here; overridden below if this token errors.
                        err_r      <= 1'b0;
                        err_code_r <= '0;
                        case (tok_kind)
                            K_PUSH: begin
                                if (depth_r == DMAX) begin
                                    err_r      <= 1'b1;
                                    err_code_r <= E_OVER;
                                    state      <= DRAIN;
                                end else begin
                                    depth_r <= depth_r + D_ONE;
                                    state   <= ISSUE;
                                end
                            end
                            K_OP: begin
                                if (tok_op[1]) begin
                                    // Binary ops consume two entries, leave one.
                                    if (depth_r >= D_TWO) begin
                                        depth_r <= depth_r - D_ONE;
                                        state   <= ISSUE;
                                    end else begin
                                        err_r      <= 1'b1;
                                        err_code_r <= E_UNDER;
                                        state      <= DRAIN;
                                    end
                                end else if (depth_r != '0) begin
                                    state <= ISSUE;
                                end else begin
                                    err_r      <= 1'b1;
                                    err_code_r <= E_UNDER;
                                    state      <= DRAIN;
                                end
                            end
                            K_END: begin
                                if (depth_r == D_ONE) begin
                                    state <= RESULT;
                                end else begin
                                    // The end token is already consumed, so no drain.
                                    err_r      <= 1'b1;
                                    err_code_r <= E_BAD;
                                    state      <= CLEAR;
                                end
                            end
                            default: begin
                                err_r      <= 1'b1;
                                err_code_r <= E_BAD;
                                state      <= DRAIN;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (STEP_GAP == 0) begin
                        state <= IDLE;
                    end else begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (!res_valid_r) begin
                        if (cnt == GAP_FULL) begin
                            res_data_r  <= calc_out;
                            res_valid_r <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (res_ready) begin
                        res_valid_r <= 1'b0;
                        state       <= CLEAR;
                    end
                end
                DRAIN: begin
                    if (tok_xfer && (tok_kind == K_END)) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    depth_r <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
